// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared binary32 types, write-back entry and buffer state encodings.
package fp_pkg;

    localparam int         EXP_W   = 8;
    localparam int         MAN_W   = 23;
    localparam logic [7:0] EXP_MAX = 8'hFF;
    localparam int         WB_TAG_W = 4;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rmode_e;

    typedef struct packed {
        fp32_t               z;
        logic                ovrf;
        logic                udrf;
        logic [WB_TAG_W-1:0] tag;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_EMPTY   = 2'd0,
        WB_PARTIAL = 2'd1,
        WB_FULL    = 2'd2
    } wb_state_e;

    // {is_nan, is_inf, is_zero, is_subnormal}
    function automatic logic [3:0] fp_class(input fp32_t v);
        logic exp_ones, exp_zero, man_zero;
        exp_ones = (v.exp == EXP_MAX);
        exp_zero = (v.exp == '0);
        man_zero = (v.man == '0);
        return {exp_ones & ~man_zero, exp_ones & man_zero,
                exp_zero & man_zero,  exp_zero & ~man_zero};
    endfunction

    function automatic logic is_inf_or_max(input fp32_t v);
        return ((v.exp == EXP_MAX) && (v.man == '0)) ||
               ({v.exp, v.man} == 31'h7F7F_FFFF);
    endfunction

endpackage

// File: rtl/fp_mul_wb_if.sv
// rtl/fp_mul_wb_if.sv - producer/consumer handshake bundle of the fp_mul write-back buffer.
interface fp_mul_wb_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_z;
    logic             in_ovrf;
    logic             in_udrf;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_z;
    logic             out_ovrf;
    logic             out_udrf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_z, in_ovrf, in_udrf, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_ovrf, out_udrf, out_tag
    );

    modport slave (
        input  in_valid, in_z, in_ovrf, in_udrf, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_ovrf, out_udrf, out_tag
    );
endinterface

// File: rtl/fp_mul_wb_fifo.sv
// rtl/fp_mul_wb_fifo.sv - generic synchronous FIFO with EMPTY/PARTIAL/FULL tracking.
module fp_mul_wb_fifo
    import fp_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  entry_t                     wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output entry_t                     rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    wb_state_e        state;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] count_dec;

    assign wr_ready  = (count != FULL_CNT);
    assign push      = wr_valid & wr_ready;
    assign pop       = rd_valid & rd_ready;
    assign count_inc = count + CNT_W'(1);
    assign count_dec = count - CNT_W'(1);
    // Head reads as zero while empty so stale entries never leak out.
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= WB_EMPTY;
            rd_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

            case (state)
                WB_EMPTY: begin
                    if (push) begin
                        count    <= count_inc;
                        rd_valid <= 1'b1;
                        state    <= WB_PARTIAL;
                    end
                end
                WB_PARTIAL: begin
                    if (push && !pop) begin
                        count <= count_inc;
                        if (count_inc == FULL_CNT) state <= WB_FULL;
                    end else if (pop && !push) begin
                        count <= count_dec;
                        if (count_dec == '0) begin
                            state    <= WB_EMPTY;
                            rd_valid <= 1'b0;
                        end
                    end
                end
                WB_FULL: begin
                    if (pop) begin
                        count <= count_dec;
                        state <= WB_PARTIAL;
                    end
                end
                default: begin
                    state    <= WB_EMPTY;
                    rd_valid <= 1'b0;
                    count    <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fp_mul_wb.sv
// rtl/fp_mul_wb.sv - fp_mul result write-back buffer with sticky exception flags.
// Optional FP_MUL_WB_CLASSIFY_EN adds head classification and an ovrf consistency flag.
module fp_mul_wb
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fp_mul_wb_if.slave                 wb,
    output logic [1:0]                 flags_sticky,
    input  logic                       flags_clr,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FP_MUL_WB_CLASSIFY_EN
    ,
    output logic [3:0]                 out_class,
    output logic                       flag_mismatch
`endif
);

    typedef struct packed {
        fp32_t            z;
        logic             ovrf;
        logic             udrf;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t wr_entry;
    entry_t rd_entry;
    logic   push;

    always_comb begin
        wr_entry      = '0;
        wr_entry.z    = wb.in_z;
        wr_entry.ovrf = wb.in_ovrf;
        wr_entry.udrf = wb.in_udrf;
        wr_entry.tag  = wb.in_tag;
    end

    fp_mul_wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wb.in_valid),
        .wr_ready (wb.in_ready),
        .wr_data  (wr_entry),
        .rd_valid (wb.out_valid),
        .rd_ready (wb.out_ready),
        .rd_data  (rd_entry),
        .count    (count)
    );

    assign push        = wb.in_valid & wb.in_ready;
    assign wb.out_z    = rd_entry.z;
    assign wb.out_ovrf = rd_entry.ovrf;
    assign wb.out_udrf = rd_entry.udrf;
    assign wb.out_tag  = rd_entry.tag;

    // A flag arriving with a clear survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_sticky <= 2'b00;
        end else begin
            flags_sticky <= (flags_clr ? 2'b00 : flags_sticky)
                          | (push ? {wb.in_ovrf, wb.in_udrf} : 2'b00);
        end
    end

`ifdef FP_MUL_WB_CLASSIFY_EN
    assign out_class = wb.out_valid ? fp_class(rd_entry.z) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_mismatch <= 1'b0;
        end else begin
            flag_mismatch <= (flags_clr ? 1'b0 : flag_mismatch)
                           | (push & wb.in_ovrf & ~is_inf_or_max(wr_entry.z));
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_wb.sv
// tb/tb_fp_mul_wb.sv - directed and randomized checks of fp_mul_wb against a queue model.
module tb_fp_mul_wb;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct {
        logic [31:0] z;
        logic        ov;
        logic        ud;
        logic [3:0]  tag;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] flags_sticky;
    logic       flags_clr = 1'b0;
    logic [2:0] count;
`ifdef FP_MUL_WB_CLASSIFY_EN
    logic [3:0] out_class;
    logic       flag_mismatch;
`endif

    int   errors = 0;
    int   checks = 0;
    ent_t mq[$];
    logic [1:0] m_sticky = 2'b00;

    fp_mul_wb_if #(.TAG_W(TAG_W)) bus ();

    fp_mul_wb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb           (bus),
        .flags_sticky (flags_sticky),
        .flags_clr    (flags_clr),
        .count        (count)
`ifdef FP_MUL_WB_CLASSIFY_EN
        ,
        .out_class    (out_class),
        .flag_mismatch(flag_mismatch)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] z, input logic ov,
                          input logic ud, input logic [3:0] tag);
        bus.in_valid = v;
        bus.in_z     = z;
        bus.in_ovrf  = ov;
        bus.in_udrf  = ud;
        bus.in_tag   = tag;
    endtask

    // Advance one clock; the model follows the handshake rules directly.
    task automatic cycle();
        bit   m_push, m_pop;
        ent_t e;
        m_push = bus.in_valid && (mq.size() < DEPTH);
        m_pop  = (mq.size() > 0) && bus.out_ready;
        e.z = bus.in_z; e.ov = bus.in_ovrf; e.ud = bus.in_udrf; e.tag = bus.in_tag;
        @(posedge clk);
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(e);
        m_sticky = (flags_clr ? 2'b00 : m_sticky) | (m_push ? {e.ov, e.ud} : 2'b00);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        ent_t h;
        h = '{z: 32'h0, ov: 1'b0, ud: 1'b0, tag: 4'h0};
        if (mq.size() > 0) h = mq[0];
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(mq.size() < DEPTH));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() > 0));
        check({tag, ".out_z"},     bus.out_z,          h.z);
        check({tag, ".out_ovrf"},  32'(bus.out_ovrf),  32'(h.ov));
        check({tag, ".out_udrf"},  32'(bus.out_udrf),  32'(h.ud));
        check({tag, ".out_tag"},   32'(bus.out_tag),   32'(h.tag));
        check({tag, ".count"},     32'(count),         32'(mq.size()));
        check({tag, ".sticky"},    32'(flags_sticky),  32'(m_sticky));
    endtask

    initial begin
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.count", 32'(count), 32'd0);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.out_z", bus.out_z, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while holding three entries
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, $urandom, 1'b1, 1'b1, 4'(i));
            cycle();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        check_all("midfill");
        rst_n = 1'b0;
        @(negedge clk);
        mq.delete();
        m_sticky = 2'b00;
        check("rst.count", 32'(count), 32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.sticky", 32'(flags_sticky), 32'd0);
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single push, held output while consumer stalls
        set_in(1'b1, 32'h4040_0000, 1'b0, 1'b0, 4'd3);
        cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        check("t2.out_valid", 32'(bus.out_valid), 32'd1);
        check("t2.out_z", bus.out_z, 32'h4040_0000);
        check("t2.out_tag", 32'(bus.out_tag), 32'd3);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2.hold_z", bus.out_z, 32'h4040_0000);
            check_all("t2.hold");
        end
        bus.out_ready = 1'b1;
        cycle();
        check("t2.drained", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Fill to full, dropped fifth push, ordered drain
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, $urandom, 1'b0, 1'b0, 4'(i));
            cycle();
        end
        check("t3.in_ready_full", 32'(bus.in_ready), 32'd0);
        set_in(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 4'hF);
        cycle();
        check("t3.count_full", 32'(count), 32'd4);
        check_all("t3.drop");
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("t3.drain_tag", 32'(bus.out_tag), 32'(i));
            cycle();
        end
        check("t3.empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h1111_0000, 1'b0, 1'b0, 4'd8);
        cycle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, $urandom, 1'b0, 1'b0, 4'(9 + i));
            check("t3.wrap_head", 32'(bus.out_tag), 32'(8 + i));
            cycle();
            check_all("t3.wrap");
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        cycle();
        bus.out_ready = 1'b0;

        // Set wins over clear, then clear alone
        flags_clr = 1'b1;
        set_in(1'b1, 32'h7F80_0000, 1'b1, 1'b0, 4'd1);
        cycle();
        check("t4.set_wins", 32'(flags_sticky), 32'h2);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        cycle();
        check("t4.cleared", 32'(flags_sticky), 32'h0);
        flags_clr = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;

        // Simultaneous push and pop at count 2
        set_in(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 4'hA);
        cycle();
        set_in(1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 4'hB);
        cycle();
        set_in(1'b1, 32'hCCCC_0003, 1'b0, 1'b1, 4'hC);
        bus.out_ready = 1'b1;
        cycle();
        check("t5.count", 32'(count), 32'd2);
        check("t5.head", 32'(bus.out_tag), 32'hB);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        cycle();
        check("t5.tail", 32'(bus.out_tag), 32'hC);
        check_all("t5");
        cycle();
        bus.out_ready = 1'b0;

`ifdef FP_MUL_WB_CLASSIFY_EN
        flags_clr = 1'b1;
        cycle();
        flags_clr = 1'b0;
        check("t6.mismatch0", 32'(flag_mismatch), 32'd0);
        set_in(1'b1, 32'h0000_0001, 1'b0, 1'b0, 4'h1);
        cycle();
        check("t6.class_sub", 32'(out_class), 32'h1);
        set_in(1'b1, 32'h3F80_0000, 1'b1, 1'b0, 4'h2);
        cycle();
        check("t6.mismatch1", 32'(flag_mismatch), 32'd1);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        bus.out_ready = 1'b1;
        repeat (2) cycle();
        bus.out_ready = 1'b0;
        flags_clr = 1'b1;
        cycle();
        flags_clr = 1'b0;
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), $urandom,
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                   4'($urandom));
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            flags_clr     = 1'($urandom_range(0, 9) == 0);
            cycle();
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
